// File: rtl/enc_sched.sv
// rtl/enc_sched.sv - AES-128 pipeline issue scheduler, origin tracker and result FIFO (optional stats: ENC_SCHED_STATS_EN)
module enc_sched #(
  parameter int NUM_REQ    = 2,
  parameter int TAG_W      = 4,
  parameter int LATENCY    = 11,
  parameter int OBUF_DEPTH = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_data,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [1407:0]            key_in,
  output logic                     enc_enable,
  output logic [127:0]             enc_plaintext,
  output logic [1407:0]            exp_key,
  input  logic [127:0]             enc_ciphertext,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [TAG_W-1:0]         out_tag,
`ifdef ENC_SCHED_STATS_EN
  output logic [NUM_REQ*32-1:0]    stat_issued,
  output logic [31:0]              stat_stall,
`endif
  output logic                     busy
);

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int AW    = $clog2(OBUF_DEPTH);

  typedef enum logic [1:0] {S_NOKEY, S_RUN, S_DRAIN, S_LOAD} state_t;
  state_t state, state_nxt;

  logic [127:0]       data_arr [NUM_REQ];
  logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
  logic [ID_W-1:0]    last_grant, win_id, hi_id, lo_id;
  logic               hi_found, lo_found, any_req;
  logic               issue_en, credit_ok, issue, drain_done;

  logic [LATENCY-1:0] trk_valid;
  logic [ID_W-1:0]    trk_id  [LATENCY];
  logic [TAG_W-1:0]   trk_tag [LATENCY];
  logic               tail_valid;
  logic [CNT_W-1:0]   in_flight;

  logic [127:0]       mem_data [OBUF_DEPTH];
  logic [ID_W-1:0]    mem_id   [OBUF_DEPTH];
  logic [TAG_W-1:0]   mem_tag  [OBUF_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_push, fifo_pop;

  assign tail_valid = trk_valid[LATENCY-1];
  assign fifo_push  = tail_valid;
  assign fifo_pop   = out_valid && out_ready;
  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_id     = out_valid ? mem_id[rd_ptr]   : '0;
  assign out_tag    = out_valid ? mem_tag[rd_ptr]  : '0;
  assign busy       = (in_flight != '0) || (fifo_count != '0);
  // Credits cover both pipeline residents and buffered results so a push can never find the FIFO full.
  assign credit_ok  = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W+1)'(OBUF_DEPTH);
  // Pipeline empties at the coming edge: nothing can be issued while draining.
  assign drain_done = (in_flight == '0) || ((in_flight == CNT_W'(1)) && tail_valid);

  // Unpack per-requester plaintext and tag lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[128*i +: 128];
      tag_arr[i]  = req_tag[TAG_W*i +: TAG_W];
    end
  end

  // Round-robin: lowest valid index above the last grant, else lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
    any_req = hi_found || lo_found;
    win_id  = hi_found ? hi_id : lo_id;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_NOKEY;
    else        state <= state_nxt;
  end

  // FSM next-state logic; a key request in RUN first drains the pipeline.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NOKEY: if (key_valid)  state_nxt = S_LOAD;
      S_RUN:   if (key_valid)  state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_LOAD;
      S_LOAD:                  state_nxt = S_RUN;
      default:                 state_nxt = S_NOKEY;
    endcase
  end

  // FSM outputs: key handshake and the single-winner issue to the pipeline.
  always_comb begin
    key_ready     = (state == S_LOAD);
    issue_en      = (state == S_RUN) && !key_valid;
    issue         = issue_en && any_req && credit_ok;
    req_ready     = '0;
    if (issue) req_ready[win_id] = 1'b1;
    enc_enable    = issue;
    enc_plaintext = issue ? data_arr[win_id] : '0;
  end

  // Remember the last winner; reset value makes the first search start at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= ID_W'(NUM_REQ - 1);
    else if (issue) last_grant <= win_id;
  end

  // Expanded key is only replaced in LOAD, when the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 exp_key <= '0;
    else if (state == S_LOAD)   exp_key <= key_in;
  end

  // Origin tracker that shadows the pipeline, one slot per stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        trk_id[i]  <= '0;
        trk_tag[i] <= '0;
      end
    end else begin
      trk_valid  <= {trk_valid[LATENCY-2:0], issue};
      trk_id[0]  <= win_id;
      trk_tag[0] <= tag_arr[win_id];
      for (int i = 1; i < LATENCY; i++) begin
        trk_id[i]  <= trk_id[i-1];
        trk_tag[i] <= trk_tag[i-1];
      end
    end
  end

  // Occupancy counters for the pipeline and the result FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({issue, tail_valid})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Result storage; the read side falls through combinationally.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_data[wr_ptr] <= enc_ciphertext;
      mem_id[wr_ptr]   <= trk_id[LATENCY-1];
      mem_tag[wr_ptr]  <= trk_tag[LATENCY-1];
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && !fifo_pop && (fifo_count == CNT_W'(OBUF_DEPTH))));

`ifdef ENC_SCHED_STATS_EN
  logic [31:0] issued_cnt [NUM_REQ];
  logic [31:0] stall_cnt;

  // Saturating per-requester issue counters and stall counter, cleared on every key load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (state == S_LOAD)) begin
      for (int i = 0; i < NUM_REQ; i++) issued_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (issue && (win_id == ID_W'(i)) && (issued_cnt[i] != '1))
          issued_cnt[i] <= issued_cnt[i] + 1'b1;
      if (any_req && !issue && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Flatten counters onto the stat ports.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) stat_issued[32*i +: 32] = issued_cnt[i];
    stat_stall = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_enc_sched.sv
// tb/tb_enc_sched.sv - self-checking bench for enc_sched with a mock 11-stage cipher pipeline
module tb_enc_sched;
  localparam int NR = 3, TW = 4, LAT = 11, DEPTH = 16, IDW = 2;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [1407:0] FIPS_KEY = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*128-1:0] req_data;
  logic [NR*TW-1:0] req_tag;
  logic key_valid, key_ready;
  logic [1407:0] key_in, exp_key;
  logic enc_enable;
  logic [127:0] enc_plaintext, enc_ciphertext;
  logic out_valid, out_ready;
  logic [127:0] out_data;
  logic [IDW-1:0] out_id;
  logic [TW-1:0] out_tag;
  logic busy;
`ifdef ENC_SCHED_STATS_EN
  logic [NR*32-1:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  enc_sched #(.NUM_REQ(NR), .TAG_W(TW), .LATENCY(LAT), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .enc_enable(enc_enable), .enc_plaintext(enc_plaintext),
    .exp_key(exp_key), .enc_ciphertext(enc_ciphertext), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_tag(out_tag),
`ifdef ENC_SCHED_STATS_EN
    .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Stand-in cipher: the FIPS-197 vector for its key, a keyed mix otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [1407:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {pt[119:0], pt[127:120]} ^ k[1407:1280] ^ k[127:0];
  endfunction

  // Mock pipeline: LAT registered stages; a key change during residency corrupts the block.
  logic [127:0] p_pt [LAT];
  logic [1407:0] p_key [LAT];
  logic p_bad [LAT];
  always @(posedge clk) begin
    p_pt[0] <= enc_plaintext;
    p_key[0] <= exp_key;
    p_bad[0] <= 1'b0;
    for (int k = 1; k < LAT; k++) begin
      p_pt[k] <= p_pt[k-1];
      p_key[k] <= p_key[k-1];
      p_bad[k] <= p_bad[k-1] || (p_key[k-1] != exp_key);
    end
  end
  assign enc_ciphertext = p_bad[LAT-1] ? ~cipher(p_pt[LAT-1], p_key[LAT-1])
                                       : cipher(p_pt[LAT-1], p_key[LAT-1]);

  // Scoreboard: accepted blocks queue in order; each popped result must match the head.
  typedef struct packed { logic [127:0] ct; logic [IDW-1:0] id; logic [TW-1:0] tag; } exp_t;
  exp_t exp_q[$];
  logic [1407:0] model_key = '0;
  int last_g = NR - 1;
  int n_acc = 0, n_pop = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      last_g = NR - 1;
    end else begin
      if (key_ready) model_key = key_in;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.ct = cipher(req_data[128*i +: 128], model_key);
          e.id = IDW'(i);
          e.tag = req_tag[TW*i +: TW];
          exp_q.push_back(e);
          last_g = i;
          n_acc++;
        end
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("unexpected_result", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.ct);
          chk("out_id", out_id, e.id);
          chk("out_tag", out_tag, e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int r = 0; r < NR; r++) req_data[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_tag = (NR*TW)'($urandom);
  endtask

  function automatic logic [1407:0] rand_key();
    logic [1407:0] k;
    for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic load_key(input logic [1407:0] k);
    int pulses;
    bit seen;
    pulses = 0;
    seen = 0;
    key_in = k;
    key_valid = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (key_ready) begin pulses++; seen = 1; end
      tick();
    end
    key_valid = 1'b0;
    chk("key_ready_seen", seen, 1'b1);
    repeat (3) begin
      @(negedge clk);
      if (key_ready) pulses++;
      tick();
    end
    chk("key_ready_pulses", pulses, 1);
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_done", (exp_q.size() == 0) && !busy, 1'b1);
  endtask

  typedef struct packed { logic [NR-1:0] v; logic [NR-1:0] rdy; } vec_t;
  vec_t tbl [10];

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0, kr, idle;
    bit resumed;
    logic [NR-1:0] exp_rdy;
    logic exp_busy;

    tbl[0] = '{3'b111, 3'b001}; tbl[1] = '{3'b111, 3'b010};
    tbl[2] = '{3'b111, 3'b100}; tbl[3] = '{3'b101, 3'b001};
    tbl[4] = '{3'b101, 3'b100}; tbl[5] = '{3'b010, 3'b010};
    tbl[6] = '{3'b000, 3'b000}; tbl[7] = '{3'b011, 3'b001};
    tbl[8] = '{3'b110, 3'b010}; tbl[9] = '{3'b001, 3'b001};

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_tag = '0;
    key_valid = 1'b0; key_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_enc_enable", enc_enable, 0);
    chk("rst_plaintext", enc_plaintext, 0);
    chk("rst_exp_key", |exp_key, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // no issue before a key is loaded
    req_valid = '1;
    rand_data();
    @(negedge clk);
    chk("nokey_no_issue", req_ready, 0);
    tick();
    req_valid = '0;
    load_key(FIPS_KEY);
    chk("exp_key_loaded", exp_key == FIPS_KEY, 1'b1);

    // arbitration table, starting from the post-reset pointer
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      rand_data();
      @(negedge clk);
      chk("arb_tbl_ready", req_ready, tbl[i].rdy);
      chk("arb_tbl_enable", enc_enable, |tbl[i].rdy);
      tick();
    end
    drain();

    // FIPS vector on requester 2, tag 3: result visible 12 cycles after presentation
    req_valid = 3'b100;
    req_data[256 +: 128] = FIPS_PT;
    req_tag[8 +: 4] = 4'd3;
    @(negedge clk);
    chk("fips_grant", req_ready, 3'b100);
    chk("fips_plaintext", enc_plaintext, FIPS_PT);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) chk("fips_not_early", out_valid, 1'b0);
      if (k == 11) begin
        chk("fips_valid", out_valid, 1'b1);
        chk("fips_data", out_data, FIPS_CT);
        chk("fips_tag", out_tag, 4'd3);
        chk("fips_id", out_id, 2'd2);
      end
    end
    drain();

    // two requesters alternate
    for (int c = 0; c < 20; c++) begin
      req_valid = 3'b011;
      rand_data();
      @(negedge clk);
      chk("alt_grant", req_ready, (c % 2 == 0) ? 3'b001 : 3'b010);
      tick();
    end
    drain();

    // backpressure: credits stop acceptance at OBUF_DEPTH
    out_ready = 1'b0;
    n0 = n_acc;
    for (int c = 0; c < 25; c++) begin
      req_valid = 3'b011;
      rand_data();
      tick();
    end
    chk("bp_accepted", n_acc - n0, DEPTH);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    tick();
    req_valid = '0;
    p0 = n_pop;
    drain();
    chk("bp_drained", n_pop - p0, DEPTH);

    // key swap mid-stream
    for (int c = 0; c < 15; c++) begin
      req_valid = 3'b011;
      rand_data();
      tick();
    end
    key_in = rand_key();
    key_valid = 1'b1;
    kr = 0; idle = 0; resumed = 0;
    for (int c = 0; c < 60 && !resumed; c++) begin
      @(negedge clk);
      if (c == 0) chk("swap_blocks_issue", req_ready, 0);
      if (key_ready) kr++;
      if (req_ready != '0) resumed = 1; else idle++;
      tick();
      if (kr != 0) key_valid = 1'b0;
      rand_data();
    end
    chk("swap_resumed", resumed, 1'b1);
    chk("swap_idle_bound", (idle >= 1) && (idle <= LAT + 1), 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (key_ready) kr++;
      tick();
      rand_data();
    end
    chk("swap_single_pulse", kr, 1);
    drain();

    // randomized traffic against the arbitration/credit model
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom);
      rand_data();
      out_ready = (c < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
      exp_rdy = '0;
      if (req_valid != '0 && exp_q.size() < DEPTH) begin
        for (int j = 1; j <= NR; j++) begin
          if (req_valid[(last_g + j) % NR]) begin
            exp_rdy[(last_g + j) % NR] = 1'b1;
            break;
          end
        end
      end
      exp_busy = (exp_q.size() != 0);
      @(negedge clk);
      chk("rand_ready", req_ready, exp_rdy);
      chk("rand_busy", busy, exp_busy);
      tick();
    end
    drain();

    // buffered results do not block a key swap; credit stalls after the swap
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req_valid = 3'b001;
      rand_data();
      tick();
    end
    req_valid = '0;
    load_key(rand_key());
    n0 = n_acc;
    for (int c = 0; c < 10; c++) begin
      req_valid = 3'b010;
      rand_data();
      tick();
    end
    req_valid = '0;
    chk("credit_accepts", n_acc - n0, 7);
`ifdef ENC_SCHED_STATS_EN
    chk("stat_issued1", stat_issued[63:32], 7);
    chk("stat_issued0", stat_issued[31:0], 0);
    chk("stat_stall", stat_stall, 3);
`endif
    drain();

    // async reset with blocks in flight
    for (int c = 0; c < 5; c++) begin
      req_valid = 3'b001;
      rand_data();
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar_req_ready", req_ready, 0);
    chk("ar_enc_enable", enc_enable, 0);
    chk("ar_key_ready", key_ready, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_exp_key", |exp_key, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("ar_no_stale", out_valid || busy, 1'b0);
      tick();
    end
    load_key(rand_key());
    for (int c = 0; c < 6; c++) begin
      req_valid = NR'($urandom);
      rand_data();
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
